// File: rtl/score_controller_pkg.sv
// Shared encodings for the Pong score path: game states and winner codes.
package score_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_WAIT = 2'd1,
    ST_PLAY       = 2'd2,
    ST_GAME_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/score_controller_frame_counter.sv
// 8-bit frame counter: increments on inc, synchronous clear has priority.
// at_limit is a combinational decode of the registered count (count == limit-1).
// No flow control; the counter advances on every cycle inc is high.
module frame_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic       at_limit
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst)      count <= 8'd0;
    else if (clr) count <= 8'd0;
    else if (inc) count <= count + 8'd1;
  end

  assign at_limit = (count == limit - 8'd1);

endmodule

// File: rtl/score_controller.sv
// Pong game sequencer: scores, serve hold, game over; SCORE_BLINK_EN blinks the winner's digit.
// All outputs registered; a point pulse is reflected one cycle later.
// No backpressure; pulses arriving in states that ignore them are dropped.
module score_controller
  import score_controller_pkg::*;
#(
  parameter int p_WIN_SCORE    = 9,
  parameter int p_SERVE_FRAMES = 60,
  parameter int p_BLINK_FRAMES = 30
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Point_P1,
  input  logic       i_Point_P2,
  output logic [3:0] o_Score_P1,
  output logic [3:0] o_Score_P2,
  output logic       o_Serve_Hold,
  output logic       o_Serve_Dir,
  output logic       o_Game_Over,
  output logic [1:0] o_Winner,
  output logic       o_Show_P1,
  output logic       o_Show_P2
);

  if (p_WIN_SCORE < 1 || p_WIN_SCORE > 9) begin : g_bad_win
    $error("p_WIN_SCORE out of range 1..9");
  end
  if (p_SERVE_FRAMES < 1 || p_SERVE_FRAMES > 255) begin : g_bad_serve
    $error("p_SERVE_FRAMES out of range 1..255");
  end
  if (p_BLINK_FRAMES < 1 || p_BLINK_FRAMES > 255) begin : g_bad_blink
    $error("p_BLINK_FRAMES out of range 1..255");
  end

  localparam logic [3:0] WIN_SCORE   = 4'(p_WIN_SCORE);
  localparam logic [7:0] SERVE_LIMIT = 8'(p_SERVE_FRAMES);

  state_t     state, state_nxt;
  logic [3:0] score_p1, score_p1_nxt, score_p2, score_p2_nxt;
  logic       hold, hold_nxt, dir, dir_nxt, game_over, game_over_nxt;
  logic [1:0] winner, winner_nxt;

  // The serve counter only runs in SERVE_WAIT, so a tick on the entry cycle is never counted.
  logic serve_at_limit, serve_done, serve_clr;
  assign serve_done = (state == ST_SERVE_WAIT) && i_Frame_Tick && serve_at_limit;
  assign serve_clr  = (state != ST_SERVE_WAIT) || serve_done;

  frame_counter u_serve_cnt (
    .clk      (i_Clk),
    .rst      (i_Reset),
    .clr      (serve_clr),
    .inc      (i_Frame_Tick),
    .limit    (SERVE_LIMIT),
    .at_limit (serve_at_limit)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state     <= ST_IDLE;
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      hold      <= 1'b1;
      dir       <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      state     <= state_nxt;
      score_p1  <= score_p1_nxt;
      score_p2  <= score_p2_nxt;
      hold      <= hold_nxt;
      dir       <= dir_nxt;
      game_over <= game_over_nxt;
      winner    <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    score_p1_nxt  = score_p1;
    score_p2_nxt  = score_p2;
    hold_nxt      = hold;
    dir_nxt       = dir;
    game_over_nxt = game_over;
    winner_nxt    = winner;
    case (state)
      ST_IDLE: begin
        if (i_Start) begin
          state_nxt    = ST_SERVE_WAIT;
          score_p1_nxt = 4'd0;
          score_p2_nxt = 4'd0;
          dir_nxt      = 1'b0;
        end
      end
      ST_SERVE_WAIT: begin
        if (serve_done) begin
          state_nxt = ST_PLAY;
          hold_nxt  = 1'b0;
        end
      end
      ST_PLAY: begin
        // Simultaneous points cancel out and play continues.
        if (i_Point_P1 ^ i_Point_P2) begin
          hold_nxt = 1'b1;
          if (i_Point_P1) begin
            score_p1_nxt = score_p1 + 4'd1;
            if (score_p1 + 4'd1 == WIN_SCORE) begin
              state_nxt     = ST_GAME_OVER;
              game_over_nxt = 1'b1;
              winner_nxt    = WIN_P1;
            end else begin
              state_nxt = ST_SERVE_WAIT;
              dir_nxt   = 1'b1;
            end
          end else begin
            score_p2_nxt = score_p2 + 4'd1;
            if (score_p2 + 4'd1 == WIN_SCORE) begin
              state_nxt     = ST_GAME_OVER;
              game_over_nxt = 1'b1;
              winner_nxt    = WIN_P2;
            end else begin
              state_nxt = ST_SERVE_WAIT;
              dir_nxt   = 1'b0;
            end
          end
        end
      end
      ST_GAME_OVER: begin
        if (i_Start) begin
          state_nxt     = ST_SERVE_WAIT;
          score_p1_nxt  = 4'd0;
          score_p2_nxt  = 4'd0;
          dir_nxt       = 1'b0;
          game_over_nxt = 1'b0;
          winner_nxt    = WIN_NONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_Score_P1   = score_p1;
  assign o_Score_P2   = score_p2;
  assign o_Serve_Hold = hold;
  assign o_Serve_Dir  = dir;
  assign o_Game_Over  = game_over;
  assign o_Winner     = winner;

`ifdef SCORE_BLINK_EN
  localparam logic [7:0] BLINK_LIMIT = 8'(p_BLINK_FRAMES);

  logic blink_at_limit, blink_done, blink_clr, show_p1, show_p2;
  assign blink_done = (state == ST_GAME_OVER) && i_Frame_Tick && blink_at_limit;
  assign blink_clr  = (state != ST_GAME_OVER) || blink_done;

  frame_counter u_blink_cnt (
    .clk      (i_Clk),
    .rst      (i_Reset),
    .clr      (blink_clr),
    .inc      (i_Frame_Tick),
    .limit    (BLINK_LIMIT),
    .at_limit (blink_at_limit)
  );

  // Both digits are solid outside GAME_OVER, so the winner's digit always enters lit.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || state != ST_GAME_OVER || i_Start) begin
      show_p1 <= 1'b1;
      show_p2 <= 1'b1;
    end else if (blink_done) begin
      if (winner == WIN_P1) show_p1 <= ~show_p1;
      if (winner == WIN_P2) show_p2 <= ~show_p2;
    end
  end

  assign o_Show_P1 = show_p1;
  assign o_Show_P2 = show_p2;
`else
  assign o_Show_P1 = 1'b1;
  assign o_Show_P2 = 1'b1;
`endif

endmodule

// File: tb/tb_score_controller.sv
// Self-checking bench for score_controller: directed scenarios plus randomized pulses vs a game-level model.
module tb_score_controller;

  localparam int WIN   = 9;
  localparam int SERVE = 60;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, tick = 1'b0, start = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       serve_hold, serve_dir, game_over, show_p1, show_p2;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  score_controller #(
    .p_WIN_SCORE    (WIN),
    .p_SERVE_FRAMES (SERVE),
    .p_BLINK_FRAMES (BLINK)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Frame_Tick (tick),
    .i_Start      (start),
    .i_Point_P1   (p1),
    .i_Point_P2   (p2),
    .o_Score_P1   (score_p1),
    .o_Score_P2   (score_p2),
    .o_Serve_Hold (serve_hold),
    .o_Serve_Dir  (serve_dir),
    .o_Game_Over  (game_over),
    .o_Winner     (winner),
    .o_Show_P1    (show_p1),
    .o_Show_P2    (show_p2)
  );

  initial forever #5 clk = ~clk;

  // Game-level model: phase 0 idle, 1 waiting to serve, 2 rally in progress, 3 game decided.
  int         m_phase = 0, m_frames = 0, m_s1 = 0, m_s2 = 0, m_blink = 0;
  logic       m_dir = 1'b0, m_sh1 = 1'b1, m_sh2 = 1'b1;
  logic [1:0] m_win = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_frames = 0; m_s1 = 0; m_s2 = 0; m_blink = 0;
      m_dir = 1'b0; m_win = 2'b00; m_sh1 = 1'b1; m_sh2 = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_frames = 0; m_s1 = 0; m_s2 = 0; m_dir = 1'b0;
        end
        1: if (tick) begin
          m_frames++;
          if (m_frames == SERVE) m_phase = 2;
        end
        2: if (p1 != p2) begin
          if (p1) m_s1++; else m_s2++;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_phase = 3; m_win = (m_s1 == WIN) ? 2'b01 : 2'b10; m_blink = 0;
          end else begin
            m_phase = 1; m_frames = 0; m_dir = p1;
          end
        end
        default: begin
          if (start) begin
            m_phase = 1; m_frames = 0; m_s1 = 0; m_s2 = 0; m_dir = 1'b0;
            m_win = 2'b00; m_sh1 = 1'b1; m_sh2 = 1'b1;
          end else if (tick) begin
            m_blink++;
`ifdef SCORE_BLINK_EN
            if (m_blink == BLINK) begin
              m_blink = 0;
              if (m_win == 2'b01) m_sh1 = ~m_sh1; else m_sh2 = ~m_sh2;
            end
`endif
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [15:0] act, exp;
      act = {score_p1, score_p2, serve_hold, serve_dir, game_over, winner, show_p1, show_p2};
      exp = {4'(m_s1), 4'(m_s2), (m_phase != 2), m_dir, (m_phase == 3), m_win, m_sh1, m_sh2};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic s, input logic a, input logic b);
    rst = r; tick = t; start = s; p1 = a; p2 = b;
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; start = 1'b0; p1 = 1'b0; p2 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cmp_en = 1'b1;
    chk("reset_score_p1", score_p1, 0);
    chk("reset_score_p2", score_p2, 0);
    chk("reset_hold", serve_hold, 1);
    chk("reset_dir", serve_dir, 0);
    chk("reset_winner", winner, 0);
    chk("reset_show", {show_p1, show_p2}, 3);
    ticks(5);
    chk("idle_ignores_ticks", serve_hold, 1);

    cyc(0, 1, 1, 0, 0);          // tick on the start cycle must not count
    ticks(SERVE - 1);
    chk("hold_before_last_tick", serve_hold, 1);
    ticks(1);
    chk("hold_drops_after_60", serve_hold, 0);
    chk("serve_dir_start", serve_dir, 0);

    cyc(0, 0, 0, 1, 0);
    chk("p1_point_score", score_p1, 1);
    chk("p1_point_hold", serve_hold, 1);
    chk("p1_point_dir", serve_dir, 1);
    cyc(0, 0, 0, 0, 1);
    chk("point_ignored_in_hold", score_p2, 0);

    ticks(SERVE);
    cyc(0, 0, 0, 1, 1);
    chk("both_points_p1", score_p1, 1);
    chk("both_points_p2", score_p2, 0);
    chk("both_points_hold", serve_hold, 0);

    for (int i = 2; i <= 8; i++) begin
      cyc(0, 0, 0, 1, 0);
      ticks(SERVE);
    end
    chk("p1_at_8", score_p1, 8);
    cyc(0, 0, 0, 1, 0);
    chk("win_score", score_p1, 9);
    chk("win_game_over", game_over, 1);
    chk("win_winner", winner, 1);
    chk("win_hold", serve_hold, 1);
    cyc(0, 0, 0, 0, 1);
    chk("frozen_p2", score_p2, 0);

    ticks(1);
    chk("blink_one_tick", show_p1, 1);
    ticks(1);
`ifdef SCORE_BLINK_EN
    chk("blink_p1_off", show_p1, 0);
`else
    chk("blink_p1_const", show_p1, 1);
`endif
    chk("blink_p2_on", show_p2, 1);
    cyc(0, 0, 1, 0, 0);
    chk("restart_scores", {score_p1, score_p2}, 0);
    chk("restart_show_p1", show_p1, 1);
    chk("restart_go_winner", {game_over, winner}, 0);
    chk("restart_hold", serve_hold, 1);

    for (int i = 0; i < 5; i++) begin
      ticks(SERVE);
      cyc(0, 0, 0, 0, 1);
    end
    chk("p2_at_5", score_p2, 5);
    ticks(10);
    cyc(1, 0, 0, 0, 0);
    chk("midgame_reset_scores", {score_p1, score_p2}, 0);
    chk("midgame_reset_hold", serve_hold, 1);
    ticks(SERVE + 10);
    chk("idle_after_reset", serve_hold, 1);

    for (int i = 0; i < 30000; i++) begin
      cyc(($urandom_range(0, 7999) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 149) == 0), ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 14) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Game-level sequencer for the Pong score path. Counts points per player, drives the two 4-bit scores into the per-player score display instances, and gates the ball via a serve hold.
- Detects game over and blinks the winner's digit.
- Sits between the ball/collision logic (point pulses) and the score display pair. Frame-rate timing comes from the VGA sync generator's end-of-frame pulse.

Parameters:
- p_WIN_SCORE, 9: score that ends the game; legal range 1..9.
- p_SERVE_FRAMES, 60: frames the ball is held after a point or game start; range 1..255.
- p_BLINK_FRAMES, 30: frames per blink half-period in GAME_OVER; range 1..255.

Ports:
- i_Clk  in  1  pixel clock; the single clock for the block.
- i_Reset  in  1  synchronous reset, active-high.
- i_Frame_Tick  in  1  one-cycle pulse per video frame.
- i_Start  in  1  one-cycle pulse; starts or restarts a game.
- i_Point_P1  in  1  one-cycle pulse; player 1 scored.
- i_Point_P2  in  1  one-cycle pulse; player 2 scored.
- o_Score_P1  out  4  player 1 score, binary 0..9.
- o_Score_P2  out  4  player 2 score, binary 0..9.
- o_Serve_Hold  out  1  1 = ball frozen at centre.
- o_Serve_Dir  out  1  0 = serve toward P1, 1 = serve toward P2.
- o_Game_Over  out  1  1 while in GAME_OVER.
- o_Winner  out  2  00 none, 01 P1, 10 P2.
- o_Show_P1  out  1  enable for P1 score video.
- o_Show_P2  out  1  enable for P2 score video.

Behaviour:
- All outputs are registered.
- Reset values: scores 0, o_Serve_Hold 1, o_Serve_Dir 0, o_Game_Over 0, o_Winner 00, o_Show_P1 1, o_Show_P2 1, state IDLE, counters 0.
- States and transitions:
  - IDLE: i_Start -> SERVE_WAIT. Scores cleared, o_Serve_Dir=0, frame counter cleared.
  - SERVE_WAIT: o_Serve_Hold=1. Each i_Frame_Tick increments the frame counter. When the counter reaches p_SERVE_FRAMES-1 and i_Frame_Tick is high -> PLAY, with o_Serve_Hold=0 from the next cycle. Point pulses are ignored.
  - PLAY, exactly one point pulse: the scorer's score increments. The new value is visible on the output the cycle after the pulse (latency 1).
    - New score == p_WIN_SCORE -> GAME_OVER; o_Winner set in the same update; o_Serve_Hold=1.
    - Otherwise -> SERVE_WAIT, counter cleared, o_Serve_Dir points toward the conceding player (P1 scored -> 1, P2 scored -> 0).
  - PLAY, both point pulses in the same cycle: no score change, state stays PLAY.
  - GAME_OVER: scores frozen, o_Serve_Hold=1, o_Game_Over=1. i_Start clears scores and o_Winner, sets o_Serve_Dir=0 -> SERVE_WAIT.
- i_Start in SERVE_WAIT or PLAY is ignored.
- Scores never exceed p_WIN_SCORE; no wrap-around is possible.
- i_Frame_Tick coincident with a state entry is not counted in the new state.
- Reset mid-game returns to IDLE with reset values on the next edge; no partial update survives.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined: in GAME_OVER a blink counter advances on i_Frame_Tick and toggles the winner's o_Show_Px every p_BLINK_FRAMES frames. The loser's enable stays 1. The winner's enable starts at 1 on GAME_OVER entry and is forced back to 1 on exit.
- Not defined: o_Show_P1 and o_Show_P2 are constant 1, and no blink counter is built.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, SERVE_WAIT=2'd1, PLAY=2'd2, GAME_OVER=2'd3) and winner codes.
- One natural sub-module: frame_counter, an 8-bit counter that increments on tick, has a synchronous clear, and flags terminal count at a given limit. It is instantiated for the serve delay and, under SCORE_BLINK_EN, for the blink period.

Test Plan:
- Reset, pulse i_Start, 60 frame ticks -> o_Serve_Hold drops the cycle after the 60th tick; scores 0/0; o_Serve_Dir=0.
- In PLAY, pulse i_Point_P1 -> o_Score_P1=1 the next cycle; o_Serve_Hold=1; o_Serve_Dir=1. Point pulses during the hold are ignored.
- With P1 at 8, pulse i_Point_P1 -> o_Score_P1=9, o_Game_Over=1, o_Winner=01. A further i_Point_P2 leaves o_Score_P2 unchanged.
- In PLAY, pulse i_Point_P1 and i_Point_P2 together -> both scores unchanged, o_Serve_Hold stays 0.
- In GAME_OVER with SCORE_BLINK_EN and p_BLINK_FRAMES=2, send 2 ticks -> o_Show_P1 goes 0, o_Show_P2 stays 1. Pulse i_Start -> scores 0/0, o_Show_P1=1, state SERVE_WAIT.
- Assert i_Reset mid-SERVE_WAIT with P2=5 -> next cycle scores 0/0, state IDLE; i_Frame_Tick pulses then have no effect until i_Start.
